// File: rtl/debug_controller_if.sv
// Host-debug bundle between debug_controller and its UART / core / imem neighbours.
interface debug_controller_if #(
  parameter int unsigned SIZE = 32,
  parameter int unsigned BYTE = 8
);
  logic [BYTE-1:0] i_rx_data;
  logic            i_rx_valid;
  logic            i_tx_ready;
  logic            i_halt;
  logic [SIZE-1:0] i_pc;
  logic            o_stall;
  logic            o_imem_we;
  logic [SIZE-1:0] o_imem_addr;
  logic [SIZE-1:0] o_imem_data;
  logic [BYTE-1:0] o_tx_data;
  logic            o_tx_valid;

  // Controller side
  modport master (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_pc,
    output o_stall, o_imem_we, o_imem_addr, o_imem_data, o_tx_data, o_tx_valid
  );

  // Environment side (UART, core, instruction memory)
  modport slave (
    output i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_pc,
    input  o_stall, o_imem_we, o_imem_addr, o_imem_data, o_tx_data, o_tx_valid
  );
endinterface

// File: rtl/debug_controller.sv
// Host command decoder: program load, run, single-step, halt and PC dump over UART.
module debug_controller (
  input  logic clk,
  input  logic rst,
  debug_controller_if.master dbg
);
  localparam int unsigned SIZE       = 32;
  localparam int unsigned BYTE       = 8;
  localparam int unsigned WORD_BYTES = SIZE / BYTE;
  localparam int unsigned BCNT_W     = $clog2(WORD_BYTES);
  localparam int unsigned CNT_W      = BYTE + 1;

  localparam logic [BYTE-1:0] CMD_LOAD = 8'h4C;
  localparam logic [BYTE-1:0] CMD_CONT = 8'h43;
  localparam logic [BYTE-1:0] CMD_STEP = 8'h53;
  localparam logic [BYTE-1:0] CMD_PC   = 8'h50;
  localparam logic [BYTE-1:0] CMD_HALT = 8'h48;
  localparam logic [BYTE-1:0] RSP_ACK  = 8'h4B;

  typedef enum logic [2:0] {
    IDLE, LOAD_CNT, LOAD_BYTES, WRITE, RUN, STEP, SEND_PC, ACK
  } state_t;

  state_t              r_state,      w_state_nxt;
  logic [SIZE-1:0]     r_word,       w_word_nxt;
  logic [SIZE-1:0]     r_pc,         w_pc_nxt;
  logic [BCNT_W-1:0]   r_byte_cnt,   w_byte_cnt_nxt;
  logic [CNT_W-1:0]    r_word_idx,   w_word_idx_nxt;
  logic [CNT_W-1:0]    r_word_cnt,   w_word_cnt_nxt;
  logic                r_stall,      w_stall_nxt;
  logic                r_imem_we,    w_imem_we_nxt;
  logic [SIZE-1:0]     r_imem_addr,  w_imem_addr_nxt;
  logic [SIZE-1:0]     r_imem_data,  w_imem_data_nxt;
  logic                r_tx_valid,   w_tx_valid_nxt;
  logic [BYTE-1:0]     r_tx_data,    w_tx_data_nxt;

  logic [SIZE-1:0]     w_word_shift;
  logic [CNT_W-1:0]    w_idx_inc;
  logic                w_tx_fire;
  logic                w_last_byte;

  assign w_word_shift = {r_word[SIZE-BYTE-1:0], dbg.i_rx_data};
  assign w_idx_inc    = r_word_idx + CNT_W'(1);
  assign w_tx_fire    = r_tx_valid & dbg.i_tx_ready;
  assign w_last_byte  = (r_byte_cnt == BCNT_W'(WORD_BYTES - 1));

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_pc        <= '0;
      r_byte_cnt  <= '0;
      r_word_idx  <= '0;
      r_word_cnt  <= '0;
      r_stall     <= 1'b1;
      r_imem_we   <= 1'b0;
      r_imem_addr <= '0;
      r_imem_data <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_word      <= w_word_nxt;
      r_pc        <= w_pc_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_word_idx  <= w_word_idx_nxt;
      r_word_cnt  <= w_word_cnt_nxt;
      r_stall     <= w_stall_nxt;
      r_imem_we   <= w_imem_we_nxt;
      r_imem_addr <= w_imem_addr_nxt;
      r_imem_data <= w_imem_data_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_tx_data   <= w_tx_data_nxt;
    end
  end

  // Next-state and next-output decode; the core stays frozen unless explicitly released
  always_comb begin
    w_state_nxt     = r_state;
    w_word_nxt      = r_word;
    w_pc_nxt        = r_pc;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_word_idx_nxt  = r_word_idx;
    w_word_cnt_nxt  = r_word_cnt;
    w_stall_nxt     = 1'b1;
    w_imem_we_nxt   = 1'b0;
    w_imem_addr_nxt = r_imem_addr;
    w_imem_data_nxt = r_imem_data;
    w_tx_valid_nxt  = r_tx_valid;
    w_tx_data_nxt   = r_tx_data;

    case (r_state)
      IDLE: begin
        if (dbg.i_rx_valid) begin
          case (dbg.i_rx_data)
            CMD_LOAD: w_state_nxt = LOAD_CNT;
            CMD_CONT: begin
              w_state_nxt = RUN;
              w_stall_nxt = 1'b0;
            end
            CMD_STEP: begin
              w_state_nxt = STEP;
              w_stall_nxt = 1'b0;
            end
            CMD_PC: begin
              // Snapshot the PC once; remaining bytes shift out of r_pc
              w_state_nxt    = SEND_PC;
              w_pc_nxt       = {dbg.i_pc[SIZE-BYTE-1:0], {BYTE{1'b0}}};
              w_tx_data_nxt  = dbg.i_pc[SIZE-1 -: BYTE];
              w_tx_valid_nxt = 1'b1;
              w_byte_cnt_nxt = '0;
            end
            default: w_state_nxt = IDLE;
          endcase
        end
      end

      LOAD_CNT: begin
        if (dbg.i_rx_valid) begin
          w_word_cnt_nxt = (dbg.i_rx_data == '0) ? CNT_W'(1 << BYTE)
                                                 : CNT_W'(dbg.i_rx_data);
          w_word_idx_nxt = '0;
          w_byte_cnt_nxt = '0;
          w_state_nxt    = LOAD_BYTES;
        end
      end

      LOAD_BYTES: begin
        if (dbg.i_rx_valid) begin
          w_word_nxt     = w_word_shift;
          w_byte_cnt_nxt = r_byte_cnt + BCNT_W'(1);
          if (w_last_byte) begin
            w_state_nxt     = WRITE;
            w_imem_we_nxt   = 1'b1;
            w_imem_addr_nxt = SIZE'({r_word_idx, {BCNT_W{1'b0}}});
            w_imem_data_nxt = w_word_shift;
          end
        end
      end

      WRITE: begin
        w_word_idx_nxt = w_idx_inc;
        if (w_idx_inc == r_word_cnt) begin
          w_state_nxt    = ACK;
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = RSP_ACK;
        end else begin
          w_state_nxt = LOAD_BYTES;
          // A byte landing in the write cycle starts the next word
          if (dbg.i_rx_valid) begin
            w_word_nxt     = w_word_shift;
            w_byte_cnt_nxt = r_byte_cnt + BCNT_W'(1);
          end
        end
      end

      RUN: begin
        if (dbg.i_halt || (dbg.i_rx_valid && (dbg.i_rx_data == CMD_HALT))) begin
          w_state_nxt    = ACK;
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = RSP_ACK;
        end else begin
          w_stall_nxt = 1'b0;
        end
      end

      STEP: w_state_nxt = IDLE;

      SEND_PC: begin
        if (w_tx_fire) begin
          if (w_last_byte) begin
            w_tx_valid_nxt = 1'b0;
            w_state_nxt    = IDLE;
          end else begin
            w_tx_data_nxt  = r_pc[SIZE-1 -: BYTE];
            w_pc_nxt       = {r_pc[SIZE-BYTE-1:0], {BYTE{1'b0}}};
            w_byte_cnt_nxt = r_byte_cnt + BCNT_W'(1);
          end
        end
      end

      ACK: begin
        if (w_tx_fire) begin
          w_tx_valid_nxt = 1'b0;
          w_state_nxt    = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign dbg.o_stall     = r_stall;
  assign dbg.o_imem_we   = r_imem_we;
  assign dbg.o_imem_addr = r_imem_addr;
  assign dbg.o_imem_data = r_imem_data;
  assign dbg.o_tx_valid  = r_tx_valid;
  assign dbg.o_tx_data   = r_tx_data;
endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller: one task per scenario, inline expected-value checks.
module tb_debug_controller;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   stall_low = 0;

  logic [7:0]  tx_q[$];
  logic [31:0] we_addr_q[$];
  logic [31:0] we_data_q[$];

  debug_controller_if dbg ();
  debug_controller dut (.clk(clk), .rst(rst), .dbg(dbg));

  always #5 clk = ~clk;

  // Record every tx transfer, every imem write cycle and every running cycle
  always @(posedge clk) begin
    if (dbg.o_tx_valid && dbg.i_tx_ready) tx_q.push_back(dbg.o_tx_data);
    if (dbg.o_imem_we) begin
      we_addr_q.push_back(dbg.o_imem_addr);
      we_data_q.push_back(dbg.o_imem_data);
    end
    if (rst && !dbg.o_stall) stall_low++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    dbg.i_rx_data  = b;
    dbg.i_rx_valid = 1'b1;
    @(negedge clk);
    dbg.i_rx_valid = 1'b0;
  endtask

  task automatic drain_ack(input string tag);
    dbg.i_tx_ready = 1'b1;
    @(negedge clk);
    dbg.i_tx_ready = 1'b0;
    n_checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h4B) begin
      n_fail++;
      $display("FAIL %s_ack got_n=%0d got0=%h exp=4b", tag, tx_q.size(),
               (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
    end
    tx_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    dbg.i_rx_data = '0; dbg.i_rx_valid = 1'b0; dbg.i_tx_ready = 1'b0;
    dbg.i_halt = 1'b0; dbg.i_pc = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (dbg.o_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall got=%b exp=1", dbg.o_stall); end
    n_checks++; if (dbg.o_imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", dbg.o_imem_we); end
    n_checks++; if (dbg.o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", dbg.o_imem_addr); end
    n_checks++; if (dbg.o_imem_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", dbg.o_imem_data); end
    n_checks++; if (dbg.o_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_txv got=%b exp=0", dbg.o_tx_valid); end
    n_checks++; if (dbg.o_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_txd got=%h exp=00", dbg.o_tx_data); end
  endtask

  task automatic test_step;
    int s0;
    s0 = stall_low;
    tx_q.delete();
    send_byte(8'h53);
    n_checks++; if (dbg.o_stall !== 1'b0) begin n_fail++; $display("FAIL step_run got=%b exp=0", dbg.o_stall); end
    @(negedge clk);
    n_checks++; if (dbg.o_stall !== 1'b1) begin n_fail++; $display("FAIL step_stop got=%b exp=1", dbg.o_stall); end
    repeat (2) @(negedge clk);
    n_checks++; if (stall_low - s0 != 1) begin n_fail++; $display("FAIL step_len got=%0d exp=1", stall_low - s0); end
    n_checks++; if (dbg.o_tx_valid !== 1'b0 || tx_q.size() != 0) begin n_fail++; $display("FAIL step_tx got_v=%b got_n=%0d exp=0", dbg.o_tx_valid, tx_q.size()); end
  endtask

  task automatic test_load;
    logic [7:0] seq [10];
    int s0;
    seq = '{8'h4C, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h04};
    s0 = stall_low;
    tx_q.delete(); we_addr_q.delete(); we_data_q.delete();
    dbg.i_tx_ready = 1'b0;
    foreach (seq[i]) send_byte(seq[i]);
    @(negedge clk);
    n_checks++; if (dbg.o_tx_valid !== 1'b1 || dbg.o_tx_data !== 8'h4B) begin n_fail++; $display("FAIL load_ack_v got=%b/%h exp=1/4b", dbg.o_tx_valid, dbg.o_tx_data); end
    @(negedge clk);
    n_checks++; if (dbg.o_tx_valid !== 1'b1 || dbg.o_tx_data !== 8'h4B) begin n_fail++; $display("FAIL load_ack_hold got=%b/%h exp=1/4b", dbg.o_tx_valid, dbg.o_tx_data); end
    drain_ack("load");
    n_checks++; if (dbg.o_tx_valid !== 1'b0) begin n_fail++; $display("FAIL load_ack_clear got=%b exp=0", dbg.o_tx_valid); end
    n_checks++;
    if (we_addr_q.size() != 2) begin
      n_fail++; $display("FAIL load_we_count got=%0d exp=2", we_addr_q.size());
    end else begin
      n_checks++; if (we_addr_q[0] !== 32'h0 || we_data_q[0] !== 32'h20010005) begin n_fail++; $display("FAIL load_w0 got=%h:%h exp=0:20010005", we_addr_q[0], we_data_q[0]); end
      n_checks++; if (we_addr_q[1] !== 32'h4 || we_data_q[1] !== 32'h8C220004) begin n_fail++; $display("FAIL load_w1 got=%h:%h exp=4:8c220004", we_addr_q[1], we_data_q[1]); end
    end
    n_checks++; if (stall_low != s0) begin n_fail++; $display("FAIL load_stall got=%0d exp=0", stall_low - s0); end
  endtask

  // 256-word load (count byte 0) streamed one byte per clock, so each word's
  // first byte lands in the preceding write cycle
  task automatic test_back_to_back;
    int bad, first_bad, wait_cnt;
    logic [31:0] exp_w;
    tx_q.delete(); we_addr_q.delete(); we_data_q.delete();
    dbg.i_tx_ready = 1'b1;
    @(negedge clk);
    dbg.i_rx_valid = 1'b1;
    dbg.i_rx_data = 8'h4C; @(negedge clk);
    dbg.i_rx_data = 8'h00; @(negedge clk);
    for (int w = 0; w < 256; w++) begin
      exp_w = {w[7:0], ~w[7:0], 8'hA5, w[7:0]};
      for (int b = 3; b >= 0; b--) begin
        dbg.i_rx_data = exp_w[b*8 +: 8];
        @(negedge clk);
      end
    end
    dbg.i_rx_valid = 1'b0;
    wait_cnt = 0;
    while (tx_q.size() == 0 && wait_cnt < 20) begin @(negedge clk); wait_cnt++; end
    dbg.i_tx_ready = 1'b0;
    n_checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h4B) begin n_fail++; $display("FAIL b2b_ack got_n=%0d exp=1x4b", tx_q.size()); end
    n_checks++;
    if (we_addr_q.size() != 256) begin
      n_fail++; $display("FAIL b2b_we_count got=%0d exp=256", we_addr_q.size());
    end else begin
      bad = 0; first_bad = -1;
      for (int w = 0; w < 256; w++) begin
        exp_w = {w[7:0], ~w[7:0], 8'hA5, w[7:0]};
        if (we_addr_q[w] !== 32'(w * 4) || we_data_q[w] !== exp_w) begin
          bad++;
          if (first_bad < 0) first_bad = w;
        end
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_words bad=%0d first=%0d got=%h:%h", bad, first_bad, we_addr_q[first_bad], we_data_q[first_bad]); end
      n_checks++; if (we_addr_q[255] !== 32'h3FC) begin n_fail++; $display("FAIL b2b_last_addr got=%h exp=3fc", we_addr_q[255]); end
    end
    tx_q.delete();
  endtask

  task automatic test_run;
    int s0;
    tx_q.delete();
    dbg.i_halt = 1'b0;
    dbg.i_tx_ready = 1'b0;
    s0 = stall_low;
    send_byte(8'h43);
    n_checks++; if (dbg.o_stall !== 1'b0) begin n_fail++; $display("FAIL run_start got=%b exp=0", dbg.o_stall); end
    repeat (9) @(negedge clk);
    n_checks++; if (dbg.o_stall !== 1'b0) begin n_fail++; $display("FAIL run_mid got=%b exp=0", dbg.o_stall); end
    dbg.i_halt = 1'b1;
    @(negedge clk);
    n_checks++; if (dbg.o_stall !== 1'b1) begin n_fail++; $display("FAIL run_halt got=%b exp=1", dbg.o_stall); end
    dbg.i_halt = 1'b0;
    n_checks++; if (stall_low - s0 != 10) begin n_fail++; $display("FAIL run_len got=%0d exp=10", stall_low - s0); end
    n_checks++; if (dbg.o_tx_valid !== 1'b1 || dbg.o_tx_data !== 8'h4B) begin n_fail++; $display("FAIL run_ack_v got=%b/%h exp=1/4b", dbg.o_tx_valid, dbg.o_tx_data); end
    drain_ack("run");
  endtask

  task automatic test_halt_on_entry;
    int s0;
    tx_q.delete();
    dbg.i_halt = 1'b1;
    s0 = stall_low;
    send_byte(8'h43);
    n_checks++; if (dbg.o_stall !== 1'b0) begin n_fail++; $display("FAIL hentry_run got=%b exp=0", dbg.o_stall); end
    @(negedge clk);
    dbg.i_halt = 1'b0;
    n_checks++; if (dbg.o_stall !== 1'b1 || stall_low - s0 != 1) begin n_fail++; $display("FAIL hentry_len got=%b/%0d exp=1/1", dbg.o_stall, stall_low - s0); end
    drain_ack("hentry");
  endtask

  task automatic test_ignored;
    int s0;
    tx_q.delete();
    s0 = stall_low;
    send_byte(8'h7A);
    repeat (3) @(negedge clk);
    n_checks++; if (dbg.o_stall !== 1'b1 || dbg.o_tx_valid !== 1'b0 || stall_low != s0) begin n_fail++; $display("FAIL ign_idle got=%b/%b/%0d exp=1/0/0", dbg.o_stall, dbg.o_tx_valid, stall_low - s0); end
    send_byte(8'h43);
    send_byte(8'h53);
    repeat (3) @(negedge clk);
    n_checks++; if (dbg.o_stall !== 1'b0 || dbg.o_tx_valid !== 1'b0) begin n_fail++; $display("FAIL ign_run got=%b/%b exp=0/0", dbg.o_stall, dbg.o_tx_valid); end
    send_byte(8'h48);
    n_checks++; if (dbg.o_stall !== 1'b1 || dbg.o_tx_valid !== 1'b1) begin n_fail++; $display("FAIL ign_hcmd got=%b/%b exp=1/1", dbg.o_stall, dbg.o_tx_valid); end
    drain_ack("ign");
  endtask

  task automatic test_pc;
    int wait_cnt;
    tx_q.delete();
    dbg.i_tx_ready = 1'b0;
    dbg.i_pc = 32'h0000_0040;
    send_byte(8'h50);
    dbg.i_pc = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (dbg.o_tx_valid !== 1'b1 || dbg.o_tx_data !== 8'h00) begin n_fail++; $display("FAIL pc_hold%0d got=%b/%h exp=1/00", c, dbg.o_tx_valid, dbg.o_tx_data); end
      if (c < 2) @(negedge clk);
    end
    dbg.i_tx_ready = 1'b1;
    wait_cnt = 0;
    while (tx_q.size() < 4 && wait_cnt < 20) begin @(negedge clk); wait_cnt++; end
    dbg.i_tx_ready = 1'b0;
    n_checks++;
    if (tx_q.size() != 4 || {tx_q[0], tx_q[1], tx_q[2], tx_q[3]} !== 32'h0000_0040) begin
      n_fail++; $display("FAIL pc_bytes got_n=%0d exp=00000040", tx_q.size());
    end
    @(negedge clk);
    n_checks++; if (dbg.o_tx_valid !== 1'b0) begin n_fail++; $display("FAIL pc_end got=%b exp=0", dbg.o_tx_valid); end
    tx_q.delete();
    dbg.i_pc = 32'hA1B2_C3D4;
    dbg.i_tx_ready = 1'b1;
    send_byte(8'h50);
    dbg.i_pc = 32'h1234_5678;
    wait_cnt = 0;
    while (tx_q.size() < 4 && wait_cnt < 20) begin @(negedge clk); wait_cnt++; end
    repeat (2) @(negedge clk);
    dbg.i_tx_ready = 1'b0;
    n_checks++;
    if (tx_q.size() != 4 || {tx_q[0], tx_q[1], tx_q[2], tx_q[3]} !== 32'hA1B2_C3D4) begin
      n_fail++; $display("FAIL pc_bytes2 got_n=%0d exp=a1b2c3d4", tx_q.size());
    end
    tx_q.delete();
  endtask

  task automatic test_reset_mid_load;
    int s0;
    we_addr_q.delete(); we_data_q.delete();
    send_byte(8'h4C);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b0;
    #1;
    n_checks++; if (dbg.o_stall !== 1'b1 || dbg.o_imem_we !== 1'b0 || dbg.o_tx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_ctl got=%b/%b/%b exp=1/0/0", dbg.o_stall, dbg.o_imem_we, dbg.o_tx_valid); end
    n_checks++; if (dbg.o_imem_addr !== 32'h0 || dbg.o_imem_data !== 32'h0 || dbg.o_tx_data !== 8'h00) begin n_fail++; $display("FAIL rmid_data got=%h/%h/%h exp=0/0/00", dbg.o_imem_addr, dbg.o_imem_data, dbg.o_tx_data); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send_byte(8'hCC);
    send_byte(8'hDD);
    repeat (3) @(negedge clk);
    n_checks++; if (we_addr_q.size() != 0) begin n_fail++; $display("FAIL rmid_no_we got=%0d exp=0", we_addr_q.size()); end
    s0 = stall_low;
    send_byte(8'h53);
    n_checks++; if (dbg.o_stall !== 1'b0) begin n_fail++; $display("FAIL rmid_step got=%b exp=0", dbg.o_stall); end
    @(negedge clk);
    n_checks++; if (dbg.o_stall !== 1'b1 || stall_low - s0 != 1) begin n_fail++; $display("FAIL rmid_step_end got=%b/%0d exp=1/1", dbg.o_stall, stall_low - s0); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_load();
    test_back_to_back();
    test_run();
    test_halt_on_entry();
    test_ignored();
    test_pc();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
